// File: rtl/tile_spawn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tile_spawn_ctrl
// Description : Sequencer for the 2048 tile-spawn datapath (new_tile).
//               Snapshots the board after a move and counts its empty cells.
//               It then picks a pseudo-random empty-cell index, pulses the
//               new_tile enable and captures the updated board. A board with
//               no empty cell is reported as full and nothing is spawned.
// Options     : define TILE_DBG_POS_EN to add dbg_valid/dbg_pos, which
//               override the LFSR seed of the position pick.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_spawn_ctrl #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          CELL_W = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [3:0][3:0][CELL_W-1:0]   board_in,
`ifdef TILE_DBG_POS_EN
    input  logic                          dbg_valid,
    input  logic [3:0]                    dbg_pos,
`endif
    output logic                          tile_enable,
    output logic [3:0][3:0][CELL_W-1:0]   tile_matrix,
    output logic [3:0]                    tile_position,
    input  logic [3:0][3:0][CELL_W-1:0]   tile_result,
    output logic [3:0][3:0][CELL_W-1:0]   board_out,
    output logic                          busy,
    output logic                          done,
    output logic                          full
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_COUNT = 3'd1;
    localparam logic [2:0] c_ST_PICK  = 3'd2;
    localparam logic [2:0] c_ST_SPAWN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_FULL  = 3'd5;

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    logic [2:0]                     r_state;
    logic [2:0]                     w_state_nxt;

    logic [15:0]                    r_lfsr;
    logic                           w_lfsr_fb;
    logic [4:0]                     r_zero_cnt;
    logic [4:0]                     r_rem;
    logic [3:0]                     r_idx;
    logic [3:0][3:0][CELL_W-1:0]    r_tile_matrix;
    logic [3:0]                     r_tile_position;
    logic [3:0][3:0][CELL_W-1:0]    r_board_out;

    logic [CELL_W-1:0]              w_cell;
    logic                           w_cell_zero;
    logic [4:0]                     w_cnt_sum;
    logic                           w_last;
    logic                           w_rem_lt;
    logic [4:0]                     w_seed_rem;

    logic                           w_tile_enable;
    logic                           w_busy;
    logic                           w_done;
    logic                           w_full;

    // ------------------------------------------------------------------------
    // Scan and pick helpers
    // ------------------------------------------------------------------------
    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cell      = r_tile_matrix[r_idx[3:2]][r_idx[1:0]];
    assign w_cell_zero = (w_cell == '0);
    // 5-bit count so a completely empty board (16 zeros) does not wrap
    assign w_cnt_sum   = r_zero_cnt + {4'd0, w_cell_zero};
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_rem_lt    = (r_rem < r_zero_cnt);

`ifdef TILE_DBG_POS_EN
    assign w_seed_rem  = dbg_valid ? {1'b0, dbg_pos} : r_lfsr[4:0];
`else
    assign w_seed_rem  = r_lfsr[4:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived control outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_tile_enable = 1'b0;
        w_done        = 1'b0;
        w_full        = 1'b0;
        w_busy        = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_COUNT;
                end
            end
            c_ST_COUNT: begin
                if (w_last) begin
                    w_state_nxt = (w_cnt_sum == 5'd0) ? c_ST_FULL : c_ST_PICK;
                end
            end
            c_ST_PICK: begin
                if (w_rem_lt) begin
                    w_state_nxt = c_ST_SPAWN;
                end
            end
            c_ST_SPAWN: begin
                w_tile_enable = 1'b1;
                w_state_nxt   = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_FULL: begin
                w_done      = 1'b1;
                w_full      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: free-running LFSR, board snapshot, empty-cell count and modulo pick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr          <= SEED;
            r_zero_cnt      <= 5'd0;
            r_rem           <= 5'd0;
            r_idx           <= 4'd0;
            r_tile_matrix   <= '0;
            r_tile_position <= 4'd0;
            r_board_out     <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_tile_matrix <= board_in;
                        r_zero_cnt    <= 5'd0;
                        r_idx         <= 4'd0;
                    end
                end
                c_ST_COUNT: begin
                    r_zero_cnt <= w_cnt_sum;
                    r_idx      <= r_idx + 4'd1;
                    if (w_last && (w_cnt_sum != 5'd0)) begin
                        r_rem <= w_seed_rem;
                    end
                end
                c_ST_PICK: begin
                    // zero_cnt is at least 1 here, so the subtraction terminates
                    if (w_rem_lt) begin
                        r_tile_position <= r_rem[3:0];
                    end else begin
                        r_rem <= r_rem - r_zero_cnt;
                    end
                end
                c_ST_SPAWN: begin
                    r_board_out <= tile_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign tile_enable   = w_tile_enable;
    assign tile_matrix   = r_tile_matrix;
    assign tile_position = r_tile_position;
    assign board_out     = r_board_out;
    assign busy          = w_busy;
    assign done          = w_done;
    assign full          = w_full;

endmodule
`default_nettype wire

// File: tb/tb_tile_spawn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tile_spawn_ctrl
// Description : Directed self-checking bench for tile_spawn_ctrl. Includes a
//               behavioural new_tile and a reference LFSR for the pick.
//               Define TILE_DBG_POS_EN to exercise the debug position ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_spawn_ctrl;

    localparam int          CELL_W = 12;
    localparam logic [15:0] SEED   = 16'hACE1;

    typedef logic [3:0][3:0][CELL_W-1:0] board_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    board_t     board_in = '0;
    logic       tile_enable;
    board_t     tile_matrix;
    logic [3:0] tile_position;
    board_t     tile_result;
    board_t     board_out;
    logic       busy;
    logic       done;
    logic       full;
`ifdef TILE_DBG_POS_EN
    logic       dbg_valid = 1'b0;
    logic [3:0] dbg_pos   = 4'd0;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] m_lfsr;

    tile_spawn_ctrl #(
        .SEED   (SEED),
        .CELL_W (CELL_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .board_in      (board_in),
`ifdef TILE_DBG_POS_EN
        .dbg_valid     (dbg_valid),
        .dbg_pos       (dbg_pos),
`endif
        .tile_enable   (tile_enable),
        .tile_matrix   (tile_matrix),
        .tile_position (tile_position),
        .tile_result   (tile_result),
        .board_out     (board_out),
        .busy          (busy),
        .done          (done),
        .full          (full)
    );

    always #5 clk = ~clk;

    // Behavioural new_tile: the p-th empty cell (row-major) gets 4 if p is odd, else 2
    function automatic board_t nt_model(input board_t m, input logic [3:0] p);
        board_t r;
        int     n;
        r = m;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i / 4][i % 4] == '0) begin
                if (n == int'(p)) begin
                    r[i / 4][i % 4] = p[0] ? CELL_W'(4) : CELL_W'(2);
                end
                n++;
            end
        end
        return r;
    endfunction

    function automatic int count_zero(input board_t b);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i / 4][i % 4] == '0) n++;
        end
        return n;
    endfunction

    always_comb tile_result = nt_model(tile_matrix, tile_position);

    // Reference x^16+x^14+x^13+x^11+1 sequence, running in lock step with the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One start-to-done sequence with full timing, pulse and board checks
    task automatic run_seq(input string tag, input board_t b, input bit use_dbg,
                           input logic [3:0] dbgp, input bit repulse,
                           output logic [3:0] pos_seen);
        board_t     prev;
        int         zc, done_cyc, en_cnt, busy_gap, p, r;
        logic       full_seen;
        logic [4:0] exp_rem;
        logic [3:0] exp_pos;
        bit         fin;
        prev = board_out;
        zc   = count_zero(b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
`ifdef TILE_DBG_POS_EN
        dbg_valid = use_dbg;
        dbg_pos   = dbgp;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1; en_cnt = 0; busy_gap = 0; full_seen = 1'b0;
        pos_seen = 4'd0; exp_rem = 5'd0; fin = 1'b0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (c == 16) exp_rem = use_dbg ? {1'b0, dbgp} : m_lfsr[4:0];
            if (tile_enable) begin
                en_cnt++;
                pos_seen = tile_position;
            end
            if (!busy) busy_gap++;
            if (done) begin
                done_cyc  = c;
                full_seen = full;
                fin       = 1'b1;
            end
            if (repulse && c == 5) start = 1'b1;
            if (repulse && c == 6) start = 1'b0;
        end
        chk({tag, "_finished"}, 192'(fin), 192'(1'b1));
        chk({tag, "_busy_gap"}, 192'(busy_gap), 192'(0));
        @(negedge clk);
        chk({tag, "_busy_after"}, 192'(busy), 192'(1'b0));
        chk({tag, "_done_after"}, 192'(done), 192'(1'b0));
        if (zc == 0) begin
            chk({tag, "_done_cyc"}, 192'(done_cyc), 192'(17));
            chk({tag, "_full"},     192'(full_seen), 192'(1'b1));
            chk({tag, "_en_cnt"},   192'(en_cnt), 192'(0));
            chk({tag, "_board"},    192'(board_out), 192'(prev));
        end else begin
            r       = int'(exp_rem);
            p       = r / zc + 1;
            exp_pos = 4'(r % zc);
            chk({tag, "_done_cyc"}, 192'(done_cyc), 192'(18 + p));
            chk({tag, "_full"},     192'(full_seen), 192'(1'b0));
            chk({tag, "_en_cnt"},   192'(en_cnt), 192'(1));
            chk({tag, "_pos"},      192'(pos_seen), 192'(exp_pos));
            chk({tag, "_board"},    192'(board_out), 192'(nt_model(b, exp_pos)));
        end
`ifdef TILE_DBG_POS_EN
        dbg_valid = 1'b0;
`endif
    endtask

    initial begin
        board_t     b;
        logic [3:0] pos;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",   192'(busy), 192'(1'b0));
        chk("rst_done",   192'(done), 192'(1'b0));
        chk("rst_full",   192'(full), 192'(1'b0));
        chk("rst_en",     192'(tile_enable), 192'(1'b0));
        chk("rst_pos",    192'(tile_position), 192'(4'd0));
        chk("rst_matrix", 192'(tile_matrix), 192'(0));
        chk("rst_board",  192'(board_out), 192'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // One empty cell at [1][2]
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = CELL_W'(8);
        b[1][2] = '0;
        run_seq("one_zero", b, 1'b0, 4'd0, 1'b0, pos);
        chk("one_zero_cell12", 192'(board_out[1][2]), 192'(12'd2));
        chk("one_zero_cell00", 192'(board_out[0][0]), 192'(12'd8));
        chk("one_zero_cell33", 192'(board_out[3][3]), 192'(12'd8));

        // No empty cell: full, board_out untouched
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = CELL_W'(2 << (i % 5));
        run_seq("full", b, 1'b0, 4'd0, 1'b0, pos);
        chk("full_cell12_kept", 192'(board_out[1][2]), 192'(12'd2));

        // Five empty cells, start re-pulsed during COUNT
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = CELL_W'(16);
        b[0][1] = '0; b[1][0] = '0; b[1][3] = '0; b[2][2] = '0; b[3][0] = '0;
        run_seq("repulse", b, 1'b0, 4'd0, 1'b1, pos);

        // Empty board: sixteen candidates
        b = '0;
        run_seq("empty", b, 1'b0, 4'd0, 1'b0, pos);

        // Reset asserted in PICK (cycle 17 is always PICK for a non-full board)
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = CELL_W'(32);
        b[2][3] = '0;
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   192'(busy), 192'(1'b0));
        chk("midrst_en",     192'(tile_enable), 192'(1'b0));
        chk("midrst_done",   192'(done), 192'(1'b0));
        chk("midrst_pos",    192'(tile_position), 192'(4'd0));
        chk("midrst_matrix", 192'(tile_matrix), 192'(0));
        chk("midrst_board",  192'(board_out), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq("after_rst", b, 1'b0, 4'd0, 1'b0, pos);
        chk("after_rst_cell23", 192'(board_out[2][3]), 192'(12'd2));

`ifdef TILE_DBG_POS_EN
        // dbg_pos=5 with zeros at [0][0],[2][1],[3][3]: 5 mod 3 = 2
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = CELL_W'(4);
        b[0][0] = '0; b[2][1] = '0; b[3][3] = '0;
        run_seq("dbg5", b, 1'b1, 4'd5, 1'b0, pos);
        chk("dbg5_pos",    192'(pos), 192'(4'd2));
        chk("dbg5_cell33", 192'(board_out[3][3]), 192'(12'd2));
        chk("dbg5_cell00", 192'(board_out[0][0]), 192'(12'd0));

        // dbg_pos=3 on an empty board
        b = '0;
        run_seq("dbg3", b, 1'b1, 4'd3, 1'b0, pos);
        chk("dbg3_pos",    192'(pos), 192'(4'd3));
        chk("dbg3_cell03", 192'(board_out[0][3]), 192'(12'd4));
        chk("dbg3_cell02", 192'(board_out[0][2]), 192'(12'd0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
